// File: rtl/flop_mode_pkg.sv
// Shared definitions for the T-flop-based multi-mode register bank.
// Holds the runtime mode encoding and the widest bank the design supports.
package flop_mode_pkg;

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } flop_mode_t;

    // Widest supported bank; it also sizes the per-cycle toggle popcount.
    localparam int MAX_WIDTH = 32;

endpackage : flop_mode_pkg

// File: rtl/t_ff_cell.sv
// Single-bit T flip-flop: the state inverts on a rising edge whenever t=1.
// Reset is synchronous, active-high and wins over t.
module t_ff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic state_q;
    logic state_d;

    // Next state: invert when asked to toggle, otherwise hold.
    always_comb begin
        state_d = state_q ^ t;
    end

    // State register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule : t_ff_cell

// File: rtl/t_core_flop_bank.sv
// WIDTH-bit multi-mode register (D, T, JK, SR) built from T flip-flop cells.
// A mode decoder turns (a, b) into a per-bit toggle vector each cycle; the
// top also keeps a saturating count of bit toggles and a sticky flag for
// S=R=1 in SR mode.
// Optional build macro FLOP_PARITY_EN: when defined, q_par is a register that
// tracks the even parity of q; when undefined, q_par is tied to 0.
module t_core_flop_bank
    import flop_mode_pkg::*;
#(
    parameter int WIDTH = 4,   // 1..MAX_WIDTH
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  flop_mode_t       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             sr_err,
    output logic             q_par
);

    // Popcount of up to MAX_WIDTH bits needs this many bits; the counter sum
    // is widened by the same amount so the clamp compare never overflows.
    localparam int POP_W = $clog2(MAX_WIDTH + 1);
    localparam int SUM_W = CNT_W + POP_W;
    localparam logic [SUM_W-1:0] CNT_MAX = {{POP_W{1'b0}}, {CNT_W{1'b1}}};

    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] t_vec;
    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] cnt_sum;

    logic [CNT_W-1:0] toggle_cnt_q;
    logic [CNT_W-1:0] toggle_cnt_d;
    logic             sr_err_q;
    logic             sr_err_d;

    // One T cell per bit; the bank state is simply the collection of cells.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            t_ff_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .t     (t_vec[gi]),
                .q     (q_vec[gi])
            );
        end
    endgenerate

    // Mode decoder: express each flop flavour as "which bits must flip".
    always_comb begin
        t_vec = '0;
        if (en) begin
            case (mode)
                MODE_D:  t_vec = a ^ q_vec;
                MODE_T:  t_vec = a;
                MODE_JK: t_vec = (a & ~q_vec) | (b & q_vec);
                MODE_SR: t_vec = (a & ~b & ~q_vec) | (b & ~a & q_vec);
                default: t_vec = '0;
            endcase
        end
    end

    // Count flipping bits this cycle and add to the counter, clamping at max.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {{(POP_W-1){1'b0}}, t_vec[i]};
        end
        cnt_sum = {{POP_W{1'b0}}, toggle_cnt_q} + {{CNT_W{1'b0}}, pop};
        if (cnt_sum > CNT_MAX) begin
            toggle_cnt_d = {CNT_W{1'b1}};
        end else begin
            toggle_cnt_d = cnt_sum[CNT_W-1:0];
        end
    end

    // Sticky SR conflict flag: a new conflict beats a clear in the same cycle.
    always_comb begin
        sr_err_d = sr_err_q;
        if (en && (mode == MODE_SR) && ((a & b) != '0)) begin
            sr_err_d = 1'b1;
        end else if (err_clr) begin
            sr_err_d = 1'b0;
        end
    end

    // Counter and error flag registers; reset discards any pending update.
    always_ff @(posedge clk) begin
        if (reset) begin
            toggle_cnt_q <= '0;
            sr_err_q     <= 1'b0;
        end else begin
            toggle_cnt_q <= toggle_cnt_d;
            sr_err_q     <= sr_err_d;
        end
    end

`ifdef FLOP_PARITY_EN
    logic q_par_q;
    logic q_par_d;

    // Parity of the post-edge state, so the register matches ^q every cycle.
    always_comb begin
        q_par_d = ^(q_vec ^ t_vec);
    end

    // Parity register, cleared together with the bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_par_q <= 1'b0;
        end else begin
            q_par_q <= q_par_d;
        end
    end

    assign q_par = q_par_q;
`else
    assign q_par = 1'b0;
`endif

    assign q          = q_vec;
    assign toggle_cnt = toggle_cnt_q;
    assign sr_err     = sr_err_q;

endmodule : t_core_flop_bank

// File: tb/tb_t_core_flop_bank.sv
// Scoreboard bench for t_core_flop_bank (WIDTH=4, CNT_W=8): the stimulus
// process updates a behavioural flop model and queues the expected state;
// a monitor pops one entry per clock edge and compares.
module tb_t_core_flop_bank;
    import flop_mode_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] q;
        int               cnt;
        logic             err;
        logic             par;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    flop_mode_t       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] toggle_cnt;
    logic             sr_err;
    logic             q_par;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    bit   stim_done = 1'b0;

    // Reference model state
    logic [WIDTH-1:0] m_q;
    int               m_cnt;
    logic             m_err;

    t_core_flop_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .a          (a),
        .b          (b),
        .err_clr    (err_clr),
        .q          (q),
        .toggle_cnt (toggle_cnt),
        .sr_err     (sr_err),
        .q_par      (q_par)
    );

    always #5 clk = ~clk;

    // Behavioural model: each bit follows its flop's textbook truth table.
    task automatic txn(input string name, input logic rst, input logic e,
                       input flop_mode_t md, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic clr);
        exp_t x;
        logic [WIDTH-1:0] nq;
        int flips;
        @(negedge clk);
        reset = rst; en = e; mode = md; a = av; b = bv; err_clr = clr;
        if (rst) begin
            m_q = '0; m_cnt = 0; m_err = 1'b0;
        end else begin
            nq = m_q;
            if (e) begin
                for (int i = 0; i < WIDTH; i++) begin
                    case (md)
                        MODE_D:  nq[i] = av[i];
                        MODE_T:  nq[i] = av[i] ? ~m_q[i] : m_q[i];
                        MODE_JK: begin
                            if (av[i] && bv[i])      nq[i] = ~m_q[i];
                            else if (av[i])          nq[i] = 1'b1;
                            else if (bv[i])          nq[i] = 1'b0;
                        end
                        default: begin
                            if (av[i] && !bv[i])     nq[i] = 1'b1;
                            else if (bv[i] && !av[i]) nq[i] = 1'b0;
                        end
                    endcase
                end
            end
            flips = 0;
            for (int i = 0; i < WIDTH; i++) if (nq[i] != m_q[i]) flips++;
            m_cnt = (m_cnt + flips > CNT_MAX) ? CNT_MAX : m_cnt + flips;
            if (e && md == MODE_SR && (av & bv) != '0) m_err = 1'b1;
            else if (clr)                               m_err = 1'b0;
            m_q = nq;
        end
        x.name = name;
        x.q    = m_q;
        x.cnt  = m_cnt;
        x.err  = m_err;
`ifdef FLOP_PARITY_EN
        x.par  = ^m_q;
`else
        x.par  = 1'b0;
`endif
        exp_q.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int req);
        total_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Monitor: the DUT presents a new state after every edge; compare then.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check({x.name, ".q"},   int'(q),          int'(x.q));
                check({x.name, ".cnt"}, int'(toggle_cnt), x.cnt);
                check({x.name, ".err"}, int'(sr_err),     int'(x.err));
                check({x.name, ".par"}, int'(q_par),      int'(x.par));
                $display("txn %-8s q=%h cnt=%0d err=%0b par=%0b", x.name,
                         q, toggle_cnt, sr_err, q_par);
            end
        end
    end

    // Stimulus: directed sequences followed by randomized traffic.
    initial begin
        reset = 1'b1; en = 1'b0; mode = MODE_D; a = '0; b = '0; err_clr = 1'b0;
        m_q = '0; m_cnt = 0; m_err = 1'b0;

        txn("rst0", 1, 1, MODE_D, 4'hF, 4'h0, 0);
        txn("rst1", 1, 1, MODE_D, 4'hF, 4'h0, 0);
        txn("d_a",  0, 1, MODE_D, 4'hA, 4'h0, 0);
        txn("d_5",  0, 1, MODE_D, 4'h5, 4'h0, 0);
        txn("d_5b", 0, 1, MODE_D, 4'h5, 4'h0, 0);
        txn("rst2", 1, 0, MODE_D, 4'h0, 4'h0, 0);
        txn("t_1",  0, 1, MODE_T, 4'h3, 4'h0, 0);
        txn("t_2",  0, 1, MODE_T, 4'h3, 4'h0, 0);
        txn("t_3",  0, 1, MODE_T, 4'h3, 4'h0, 0);
        txn("t_hold", 0, 0, MODE_T, 4'hF, 4'h0, 0);
        txn("jk_set", 0, 1, MODE_JK, 4'hC, 4'h3, 0);
        txn("jk_tog", 0, 1, MODE_JK, 4'hF, 4'hF, 0);
        txn("rst3", 1, 0, MODE_D, 4'h0, 4'h0, 0);
        txn("sr_set", 0, 1, MODE_SR, 4'h1, 4'h0, 0);
        txn("sr_cfl", 0, 1, MODE_SR, 4'h2, 4'h2, 0);
        txn("sr_pri", 0, 1, MODE_SR, 4'h2, 4'h2, 1);
        txn("sr_clr", 0, 1, MODE_SR, 4'h0, 4'h0, 1);
        txn("sr_dis", 0, 0, MODE_SR, 4'hF, 4'hF, 0);
        txn("rst_mid", 1, 1, MODE_T, 4'hF, 4'h0, 0);
        for (int i = 0; i < 70; i++) txn("sat", 0, 1, MODE_T, 4'hF, 4'h0, 0);
        txn("rst4", 1, 0, MODE_D, 4'h0, 4'h0, 0);
        for (int i = 0; i < 400; i++) begin
            txn("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                flop_mode_t'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                ($urandom_range(0, 3) == 0));
        end
        stim_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then report.
    initial begin
        wait (stim_done);
        repeat (4) @(posedge clk);
        #2;
        total_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_t_core_flop_bank
